// File: rtl/weight_pingpong_loader.sv
// Ping-pong weight loader: fetches a tile of kernel words into a shadow bank and
// exchanges it with the active bank on swap. Define WEIGHT_TAP_REVERSE_EN to take tap 0 from the word MSBs.
module weight_pingpong_loader #(
    parameter int Tn           = 4,
    parameter int Tm           = 8,
    parameter int KERNEL_SIZE  = 5,
    parameter int KERNEL_WIDTH = 2,
    parameter int MEM_AW       = 9,
    parameter int MEM_LAT      = 2,
    parameter int CNT_W        = 10,
    parameter int WORD_W       = KERNEL_SIZE * KERNEL_SIZE * KERNEL_WIDTH,
    parameter int NENT         = Tn * Tm
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic [MEM_AW-1:0]        load_base_addr,
    input  logic [CNT_W-1:0]         load_words,
    output logic                     load_ready,
    output logic                     load_busy,
    output logic                     load_done,
    input  logic                     swap,
    output logic                     weight_valid,
    output logic                     mem_en,
    output logic [MEM_AW-1:0]        mem_addr,
    input  logic [WORD_W-1:0]        mem_dout,
    output logic [NENT*WORD_W-1:0]   weight_wire
);

    localparam int K2 = KERNEL_SIZE * KERNEL_SIZE;
    localparam int IW = (NENT > 1) ? $clog2(NENT) : 1;
    localparam int CW = $clog2(NENT + 1);
    localparam logic [CNT_W-1:0] NENT_WORDS = CNT_W'(NENT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_r, state_n;
    logic [CW-1:0]       cnt_r, cnt_n;
    logic [IW-1:0]       idx_r, idx_n;
    logic                mem_en_r, mem_en_n;
    logic [MEM_AW-1:0]   mem_addr_r, mem_addr_n;
    logic                shadow_full_r, shadow_full_n;
    logic                weight_valid_r, weight_valid_n;
    logic                load_ready_r, load_busy_r, load_done_r;

    // Read-return tracking: one stage per cycle of memory latency.
    logic [MEM_LAT-1:0]  pipe_vld_r;
    logic [MEM_LAT-1:0]  pipe_last_r;
    logic [IW-1:0]       pipe_idx_r [MEM_LAT];

    logic [WORD_W-1:0]   active_bank_r [NENT];
    logic [WORD_W-1:0]   shadow_bank_r [NENT];

    logic                accept_s;
    logic                do_swap_s;
    logic                last_issue_s;
    logic                cap_vld_s;
    logic                cap_last_s;
    logic [IW-1:0]       cap_idx_s;
    logic [CW-1:0]       n_eff_s;

    assign accept_s     = load_start & load_ready_r;
    assign do_swap_s    = swap & shadow_full_r;
    assign n_eff_s      = (load_words > NENT_WORDS) ? CW'(NENT) : CW'(load_words);
    assign last_issue_s = (CW'(idx_r) == (cnt_r - CW'(1)));
    assign cap_vld_s    = pipe_vld_r[MEM_LAT-1];
    assign cap_last_s   = pipe_last_r[MEM_LAT-1];
    assign cap_idx_s    = pipe_idx_r[MEM_LAT-1];

    // Next-state, address sequencing and bank-status decisions.
    always_comb begin
        state_n        = state_r;
        cnt_n          = cnt_r;
        idx_n          = idx_r;
        mem_en_n       = mem_en_r;
        mem_addr_n     = mem_addr_r;
        shadow_full_n  = shadow_full_r;
        weight_valid_n = weight_valid_r;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    cnt_n      = n_eff_s;
                    idx_n      = '0;
                    mem_addr_n = load_base_addr;
                    if (n_eff_s == '0) begin
                        state_n  = DONE;
                        mem_en_n = 1'b0;
                    end else begin
                        state_n  = READ;
                        mem_en_n = 1'b1;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            READ: begin
                if (last_issue_s) begin
                    state_n  = DRAIN;
                    mem_en_n = 1'b0;
                end else begin
                    idx_n      = idx_r + IW'(1);
                    mem_addr_n = mem_addr_r + MEM_AW'(1);
                end
            end
            DRAIN: begin
                if (cap_vld_s && cap_last_s) begin
                    state_n = DONE;
                end else begin
                    state_n = DRAIN;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n  = IDLE;
                mem_en_n = 1'b0;
            end
        endcase

        // A swap can never coincide with DONE having effect: shadow_full is still clear there.
        if (state_r == DONE) begin
            shadow_full_n = 1'b1;
        end else if (do_swap_s) begin
            shadow_full_n  = 1'b0;
            weight_valid_n = 1'b1;
        end else begin
            shadow_full_n = shadow_full_r;
        end
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            cnt_r          <= '0;
            idx_r          <= '0;
            mem_en_r       <= 1'b0;
            mem_addr_r     <= '0;
            shadow_full_r  <= 1'b0;
            weight_valid_r <= 1'b0;
            load_ready_r   <= 1'b1;
            load_busy_r    <= 1'b0;
            load_done_r    <= 1'b0;
        end else begin
            state_r        <= state_n;
            cnt_r          <= cnt_n;
            idx_r          <= idx_n;
            mem_en_r       <= mem_en_n;
            mem_addr_r     <= mem_addr_n;
            shadow_full_r  <= shadow_full_n;
            weight_valid_r <= weight_valid_n;
            load_ready_r   <= (state_n == IDLE) & ~shadow_full_n;
            load_busy_r    <= (state_n != IDLE);
            load_done_r    <= (state_n == DONE);
        end
    end

    // Delay line pairing each issued address with its returning data word.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_r  <= '0;
            pipe_last_r <= '0;
            for (int s = 0; s < MEM_LAT; s++) begin
                pipe_idx_r[s] <= '0;
            end
        end else begin
            pipe_vld_r[0]  <= mem_en_r;
            pipe_last_r[0] <= mem_en_r & last_issue_s;
            pipe_idx_r[0]  <= idx_r;
            for (int s = 1; s < MEM_LAT; s++) begin
                pipe_vld_r[s]  <= pipe_vld_r[s-1];
                pipe_last_r[s] <= pipe_last_r[s-1];
                pipe_idx_r[s]  <= pipe_idx_r[s-1];
            end
        end
    end

    // Bank storage: shadow fill from memory, full exchange on an accepted swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < NENT; e++) begin
                active_bank_r[e] <= '0;
                shadow_bank_r[e] <= '0;
            end
        end else if (do_swap_s) begin
            for (int e = 0; e < NENT; e++) begin
                active_bank_r[e] <= shadow_bank_r[e];
                shadow_bank_r[e] <= active_bank_r[e];
            end
        end else if (cap_vld_s) begin
            shadow_bank_r[cap_idx_s] <= mem_dout;
        end
    end

    function automatic logic [WORD_W-1:0] tap_order(input logic [WORD_W-1:0] word);
        logic [WORD_W-1:0] taps;
        taps = '0;
        for (int k = 0; k < K2; k++) begin
`ifdef WEIGHT_TAP_REVERSE_EN
            taps[k*KERNEL_WIDTH +: KERNEL_WIDTH] = word[(K2-1-k)*KERNEL_WIDTH +: KERNEL_WIDTH];
`else
            taps[k*KERNEL_WIDTH +: KERNEL_WIDTH] = word[k*KERNEL_WIDTH +: KERNEL_WIDTH];
`endif
        end
        return taps;
    endfunction

    // Tap reordering is pure wiring on top of the registered active bank.
    for (genvar e = 0; e < NENT; e++) begin : g_wire
        assign weight_wire[e*WORD_W +: WORD_W] = tap_order(active_bank_r[e]);
    end

    assign load_ready   = load_ready_r;
    assign load_busy    = load_busy_r;
    assign load_done    = load_done_r;
    assign weight_valid = weight_valid_r;
    assign mem_en       = mem_en_r;
    assign mem_addr     = mem_addr_r;

endmodule
